store_buffer: RTL and testbench
===============================

# store_buffer

Write-behind store buffer between the memory pipeline stage and the data cache. Stores from the pipeline retire into a small FIFO in one cycle and drain to the data cache in order, one at a time, while loads are served either by forwarding from the buffer or through the data cache port. It owns the single data cache request port: it drives enable/store/word/addr/data and consumes hit/data_out.

## Interface
- ADDRESS_WIDTH, 32, byte address width.
- DEPTH, 4, entry count; power of two, ≥2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  pipeline memory request present; held stable while stall=1.
- req_store  in  1  1 = store, 0 = load.
- req_word  in  1  1 = word access, 0 = byte access.
- req_addr  in  ADDRESS_WIDTH  byte address; word accesses are word-aligned.
- req_data  in  XLEN  store data; bytes use bits [7:0].
- fence  in  1  hold the pipeline until the buffer is empty.
- stall  out  1  request not accepted this cycle.
- load_valid  out  1  load completes this cycle.
- load_data  out  XLEN  load result; bytes are zero-extended.
- dc_enable, dc_store, dc_word  out  1 each  data cache request.
- dc_addr  out  ADDRESS_WIDTH; dc_data_in  out  XLEN  data cache request fields.
- dc_hit  in  1; dc_data_out  in  XLEN  data cache response.
- empty, full  out  1 each  buffer status.

## Operation
- Entry: {addr, data, word}. FIFO uses head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count of $clog2(DEPTH)+1 bits.
- Store: if not full, the store is enqueued at the clock edge, with stall=0. If full, stall=1. A pop in the same cycle does not bypass: stall stays 1.
- Load match: scan all valid entries with addr[ADDRESS_WIDTH-1:2] equal to the load's word address and select the youngest.
  - Forwardable if the youngest match is a word store, or if both are byte accesses with equal addr[1:0].
  - Any other match is a conflict.
  - No match means the load goes to the data cache.
- Forward: load_valid=1 and stall=0 in the same cycle. The load extracts the byte selected by addr[1:0] when req_word=0.
- Load to cache: legal only in S_IDLE with no match. The block drives dc_* from the request with dc_store=0. load_valid=dc_hit, load_data=dc_data_out, stall=~dc_hit.
- Conflict: stall=1; the buffer drains until the match disappears.
- FSM states: S_IDLE, S_DRAIN.
  - S_IDLE: if a load goes to the cache, the port is used by the load. Otherwise, if not empty, the head entry is driven to dc_* with dc_store=1. On dc_hit the entry is popped and the FSM stays in S_IDLE; without dc_hit the FSM goes to S_DRAIN.
  - S_DRAIN: the head is driven until dc_hit, then popped, and the FSM returns to S_IDLE. The port is locked in this state: loads stall even when they do not match.
- fence with a non-empty buffer or with state S_DRAIN gives stall=1. Stores and loads are not accepted while the fence is waiting.
- dc_enable=0 when idle with an empty buffer and no load.

## Timing
- Reset values: count=0, pointers=0, state S_IDLE. Outputs: stall=0, load_valid=0, dc_enable=0, dc_store=0, empty=1, full=0. dc_addr, dc_data_in and load_data are 0.
- Reset asserted mid-drain discards all entries. dc_enable drops asynchronously.
- Store acceptance: 0 cycles of stall when not full. The entry is visible to forwarding on the next cycle.
- Forwarded load: combinational, same cycle.
- Cache load: completes in the first cycle in which dc_hit=1.
- Drain: one entry per dc_hit. No more than one pop per cycle.
- Simultaneous push and pop when not full: count is unchanged and the pointers advance.
- The FSM ensures the dc_* fields are stable from first assertion until dc_hit.

## Configuration
- STORE_BUFFER_FORWARD_EN defined: forwarding works as described above.
- STORE_BUFFER_FORWARD_EN undefined: no matching logic. Any load with the buffer non-empty or state S_DRAIN stalls until the buffer is empty, then goes to the cache.

## Structure
- brisc_pkg additions:
  - sb_entry_t packed struct {addr, data, word}.
  - sb_state_e enum {S_IDLE, S_DRAIN}.
  - SB_DEPTH_DEFAULT constant.
- Sub-module sb_fwd_match: combinational youngest-match search over the entry array. It outputs match, forwardable and the selected data. It is instantiated only under STORE_BUFFER_FORWARD_EN.

## Test plan
- Store word 0xDEADBEEF at address 0x100, then drain with dc_hit on the 3rd cycle. Expected: dc_store=1, dc_addr=0x100 held for 3 cycles, then the buffer is empty.
- Fill 4 stores with dc_hit=0, then issue a 5th store. Expected: full=1 and stall=1. Release with dc_hit=1: pops occur in FIFO order.
- Store word 0x11223344 at 0x200, then load byte 0x202 with dc_hit=0. Expected: load_valid=1 and load_data=0x22 in the same cycle (forward build).
- Store byte 0xAA at 0x301, then load word 0x300. Expected: stall until the entry drains, then the load goes to the cache and returns dc_data_out.
- Load to 0x400 while S_DRAIN is in progress. Expected: stall until dc_hit pops the drain, then the load is issued to the cache.
- Assert rst with 3 entries mid-drain. Expected: dc_enable=0 immediately, empty=1, and stall=0 after rst is released.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared types and constants for the store buffer slice: entry layout,
// drain FSM states and default sizing.
package brisc_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned SB_ADDR_WIDTH    = 32;
   localparam int unsigned SB_DEPTH_DEFAULT = 4;

   // One buffered store; byte stores keep their payload in data[7:0]
   typedef struct packed {
      logic [SB_ADDR_WIDTH-1:0] addr;
      logic [XLEN-1:0]          data;
      logic                     word;
   } sb_entry_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } sb_state_e;

   // Zero-extended byte lane 'off' of a word
   function automatic logic [XLEN-1:0] sb_byte_lane(input logic [XLEN-1:0] w,
                                                    input logic [1:0]      off);
      logic [XLEN-1:0] sh;
      sh = w >> {off, 3'b000};
      return XLEN'(sh[7:0]);
   endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer for load forwarding.
// Only instantiated when STORE_BUFFER_FORWARD_EN is defined.
module sb_fwd_match
   import brisc_pkg::*;
#(
   parameter  int unsigned ADDRESS_WIDTH = 32,
   parameter  int unsigned DEPTH         = SB_DEPTH_DEFAULT,
   localparam int unsigned PTR_W         = $clog2(DEPTH),
   localparam int unsigned CNT_W         = PTR_W + 1
) (
   input  sb_entry_t                entries_i [DEPTH],
   input  logic [PTR_W-1:0]         head_i,
   input  logic [CNT_W-1:0]         count_i,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr_i,
   input  logic                     ld_word_i,
   output logic                     match_o,
   output logic                     forwardable_o,
   output logic [XLEN-1:0]          data_o
);

   logic [1:0]      sel_off;
   logic [XLEN-1:0] sel_data;
   logic            sel_word;

   // Walk valid entries oldest to youngest so the last hit is the youngest
   always_comb begin
      logic [PTR_W-1:0] idx;
      match_o  = 1'b0;
      sel_off  = '0;
      sel_data = '0;
      sel_word = 1'b0;
      idx      = '0;
      for (int unsigned age = 0; age < DEPTH; age++) begin
         idx = head_i + PTR_W'(age);
         if ((age < 32'(count_i)) &&
             (entries_i[idx].addr[ADDRESS_WIDTH-1:2] == ld_addr_i[ADDRESS_WIDTH-1:2])) begin
            match_o  = 1'b1;
            sel_off  = entries_i[idx].addr[1:0];
            sel_data = entries_i[idx].data;
            sel_word = entries_i[idx].word;
         end
      end
   end

   // Decide whether the youngest hit can supply the load, and shape its data
   always_comb begin
      forwardable_o = match_o & (sel_word | (~ld_word_i & (sel_off == ld_addr_i[1:0])));
      if (ld_word_i) begin
         data_o = sel_data;
      end else if (sel_word) begin
         data_o = sb_byte_lane(sel_data, ld_addr_i[1:0]);
      end else begin
         data_o = XLEN'(sel_data[7:0]);
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Write-behind store buffer owning the data cache request port.
// Stores retire into a FIFO and drain in order; loads forward from the
// buffer or go to the cache. Optional forwarding: STORE_BUFFER_FORWARD_EN.
module store_buffer
   import brisc_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DEPTH         = SB_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic                     req_store,
   input  logic                     req_word,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [XLEN-1:0]          req_data,
   input  logic                     fence,
   output logic                     stall,
   output logic                     load_valid,
   output logic [XLEN-1:0]          load_data,
   output logic                     dc_enable,
   output logic                     dc_store,
   output logic                     dc_word,
   output logic [ADDRESS_WIDTH-1:0] dc_addr,
   output logic [XLEN-1:0]          dc_data_in,
   input  logic                     dc_hit,
   input  logic [XLEN-1:0]          dc_data_out,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   sb_entry_t        entries_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   sb_state_e        state_q, state_d;

   logic             is_load, is_store;
   logic             fence_wait;
   logic             fwd_hit, cache_ld;
   logic             drain_sel, push, pop;
   logic [XLEN-1:0]  fwd_data;
   sb_entry_t        head_ent, new_ent;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign is_load    = req_valid & ~req_store;
   assign is_store   = req_valid &  req_store;
   assign fence_wait = fence & (~empty | (state_q == S_DRAIN));
   assign head_ent   = entries_q[head_q];
   assign new_ent    = '{addr: SB_ADDR_WIDTH'(req_addr), data: req_data, word: req_word};

`ifdef STORE_BUFFER_FORWARD_EN
   logic fwd_match, fwd_ok;

   sb_fwd_match #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DEPTH         (DEPTH)
   ) u_fwd (
      .entries_i     (entries_q),
      .head_i        (head_q),
      .count_i       (count_q),
      .ld_addr_i     (req_addr),
      .ld_word_i     (req_word),
      .match_o       (fwd_match),
      .forwardable_o (fwd_ok),
      .data_o        (fwd_data)
   );

   // Forwarding needs no port, so it works in either state; a cache load
   // needs a free port and no older store to the same word
   assign fwd_hit  = is_load & fwd_match & fwd_ok & ~fence_wait;
   assign cache_ld = is_load & ~fwd_match & (state_q == S_IDLE) & ~fence_wait;
`else
   // Without matching logic any buffered store may alias, so loads wait for empty
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
   assign cache_ld = is_load & empty & (state_q == S_IDLE) & ~fence_wait;
`endif

   assign drain_sel = ~cache_ld & ~empty;
   assign push      = is_store & ~full & ~fence_wait;
   assign pop       = drain_sel & dc_hit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: lock the port in S_DRAIN while a presented store awaits its hit
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (drain_sel & ~dc_hit) state_d = S_DRAIN;
         S_DRAIN: if (dc_hit)              state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   // Outputs: port mux between cache load and head store, load result, stall
   always_comb begin
      dc_enable  = 1'b0;
      dc_store   = 1'b0;
      dc_word    = 1'b0;
      dc_addr    = '0;
      dc_data_in = '0;
      if (cache_ld) begin
         dc_enable  = 1'b1;
         dc_word    = req_word;
         dc_addr    = req_addr;
         dc_data_in = req_data;
      end else if (drain_sel) begin
         dc_enable  = 1'b1;
         dc_store   = 1'b1;
         dc_word    = head_ent.word;
         dc_addr    = ADDRESS_WIDTH'(head_ent.addr);
         dc_data_in = head_ent.data;
      end

      load_valid = fwd_hit | (cache_ld & dc_hit);
      load_data  = '0;
      if (fwd_hit) begin
         load_data = fwd_data;
      end else if (cache_ld) begin
         load_data = dc_data_out;
      end

      // A pop in the same cycle does not free a slot for a store
      stall = fence_wait | (is_store & full) | (is_load & ~load_valid);
   end

   // Pointer and occupancy next-state
   always_comb begin
      head_d = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d = push ? tail_q + PTR_W'(1) : tail_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards all entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count_q
   always_ff @(posedge clk) begin
      if (push) begin
         entries_q[tail_q] <= new_ent;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_store = 1'b0, req_word = 1'b0, fence = 1'b0;
   logic [31:0] req_addr = '0, req_data = '0;
   logic        dc_hit = 1'b0;
   logic [31:0] dc_data_out = '0;
   logic        stall, load_valid, dc_enable, dc_store, dc_word, empty, full;
   logic [31:0] load_data, dc_addr, dc_data_in;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_buffer #(
      .ADDRESS_WIDTH (32),
      .DEPTH         (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_store   (req_store),
      .req_word    (req_word),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .fence       (fence),
      .stall       (stall),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .dc_enable   (dc_enable),
      .dc_store    (dc_store),
      .dc_word     (dc_word),
      .dc_addr     (dc_addr),
      .dc_data_in  (dc_data_in),
      .dc_hit      (dc_hit),
      .dc_data_out (dc_data_out),
      .empty       (empty),
      .full        (full)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h, required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a queue of pending stores ----------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        word;
   } ent_t;

   ent_t        q[$];
   bit          inflight = 1'b0;   // a store was shown to the cache and not yet acknowledged
   bit          pend_push, pend_pop, pend_infl;
   ent_t        pend_ent;
   logic        e_stall, e_lv, e_en, e_st, e_wd;
   logic [31:0] e_ld, e_addr, e_din;

   always @(negedge clk) begin : compare
      int   n;
      bit   fw, is_ld, is_st, m, fok, fwd, to_cache, present;
      ent_t sel;
      logic [31:0] fd;
      n = q.size();
      if (rst) begin
         q.delete();
         inflight  = 1'b0;
         pend_push = 1'b0;
         pend_pop  = 1'b0;
         pend_infl = 1'b0;
         e_stall = 0; e_lv = 0; e_en = 0; e_st = 0; e_wd = 0;
         e_ld = 0; e_addr = 0; e_din = 0;
         n = 0;
      end else begin
         fw    = fence && (n != 0 || inflight);
         is_ld = req_valid && !req_store;
         is_st = req_valid && req_store;
         m = 0; fok = 0; fd = 0; sel = '{addr: 0, data: 0, word: 0};
`ifdef STORE_BUFFER_FORWARD_EN
         for (int i = 0; i < n; i++)
            if (q[i].addr[31:2] == req_addr[31:2]) begin
               m = 1;
               sel = q[i];
            end
         if (m) begin
            fok = sel.word || (!req_word && sel.addr[1:0] == req_addr[1:0]);
            if (req_word)      fd = sel.data;
            else if (sel.word) fd = (sel.data >> (8 * req_addr[1:0])) & 32'hFF;
            else               fd = sel.data & 32'hFF;
         end
         fwd      = is_ld && m && fok && !fw;
         to_cache = is_ld && !m && !inflight && !fw;
`else
         fwd      = 0;
         to_cache = is_ld && n == 0 && !inflight && !fw;
`endif
         present = !to_cache && n != 0;
         e_en = 0; e_st = 0; e_wd = 0; e_addr = 0; e_din = 0;
         if (to_cache) begin
            e_en = 1; e_wd = req_word; e_addr = req_addr; e_din = req_data;
         end else if (present) begin
            e_en = 1; e_st = 1; e_wd = q[0].word; e_addr = q[0].addr; e_din = q[0].data;
         end
         e_lv    = fwd || (to_cache && dc_hit);
         e_ld    = fwd ? fd : (to_cache ? dc_data_out : 32'h0);
         e_stall = fw || (is_st && n == 4) || (is_ld && !e_lv);
         pend_pop  = present && dc_hit;
         pend_push = is_st && n < 4 && !fw;
         pend_infl = present && !dc_hit;
         pend_ent  = '{addr: req_addr, data: req_data, word: req_word};
      end
      chk("stall", stall, e_stall);
      chk("load_valid", load_valid, e_lv);
      chk("load_data", load_data, e_ld);
      chk("dc_enable", dc_enable, e_en);
      chk("dc_store", dc_store, e_st);
      chk("dc_word", dc_word, e_wd);
      chk("dc_addr", dc_addr, e_addr);
      chk("dc_data_in", dc_data_in, e_din);
      chk("empty", empty, n == 0);
      chk("full", full, n == 4);
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (pend_pop) void'(q.pop_front());
         if (pend_push) q.push_back(pend_ent);
         inflight = pend_infl;
      end
   end

   // ---------------- directed stimulus with literal expectations -----------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      req_valid = 0; req_store = 0; req_word = 0; req_addr = 0; req_data = 0;
   endtask

   task automatic drive(input bit st, input bit wd, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1; req_store = st; req_word = wd; req_addr = a; req_data = d;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: actual timeout, required finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] order [3];
      #2;
      chk("rst_stall", stall, 0);
      chk("rst_load_valid", load_valid, 0);
      chk("rst_dc_enable", dc_enable, 0);
      chk("rst_dc_store", dc_store, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_dc_addr", dc_addr, 0);
      chk("rst_load_data", load_data, 0);
      step(); step();
      rst = 0;

      // drain one word store, hit on the 3rd cycle
      drive(1, 1, 32'h100, 32'hDEADBEEF); #1;
      chk("st100_stall", stall, 0);
      step(); idle_req(); #1;
      chk("d1_store", dc_store, 1);
      chk("d1_addr", dc_addr, 32'h100);
      chk("d1_data", dc_data_in, 32'hDEADBEEF);
      step(); #1;
      chk("d2_addr", dc_addr, 32'h100);
      step(); dc_hit = 1; #1;
      chk("d3_addr", dc_addr, 32'h100);
      step(); dc_hit = 0; #1;
      chk("d_empty", empty, 1);
      chk("d_idle_en", dc_enable, 0);

      // fill, overflow, release in FIFO order
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 32'h10 + 32'(4 * i), 32'(i + 1)); #1;
         chk("fill_stall", stall, 0);
         step();
      end
      drive(1, 1, 32'h20, 32'h5); #1;
      chk("ovf_full", full, 1);
      chk("ovf_stall", stall, 1);
      chk("ovf_head", dc_addr, 32'h10);
      step(); dc_hit = 1; #1;
      chk("ovf_pop_nobypass", stall, 1);
      chk("pop0", dc_addr, 32'h10);
      step(); #1;
      chk("ovf_accept", stall, 0);
      chk("pop1", dc_addr, 32'h14);
      step(); idle_req();
      order[0] = 32'h18; order[1] = 32'h1C; order[2] = 32'h20;
      for (int i = 0; i < 3; i++) begin
         #1; chk("pop_order", dc_addr, order[i]);
         step();
      end
      dc_hit = 0; #1;
      chk("fill_empty", empty, 1);

      // forward byte from word store
      drive(1, 1, 32'h200, 32'h11223344); step();
      drive(0, 0, 32'h202, 0); dc_data_out = 32'hFFFFFFFF; #1;
`ifdef STORE_BUFFER_FORWARD_EN
      chk("fwd_valid", load_valid, 1);
      chk("fwd_data", load_data, 32'h22);
      chk("fwd_stall", stall, 0);
`else
      chk("nofwd_stall", stall, 1);
`endif
      step(); idle_req(); dc_hit = 1; step(); dc_hit = 0; #1;
      chk("fwd_empty", empty, 1);

      // byte store then word load: wait for drain, then cache load
      drive(1, 0, 32'h301, 32'hAA); step();
      drive(0, 1, 32'h300, 0); dc_data_out = 32'hCAFEF00D; #1;
      chk("cfl_stall", stall, 1);
      step(); dc_hit = 1; #1;
      chk("cfl_drain_stall", stall, 1);
      chk("cfl_drain_addr", dc_addr, 32'h301);
      step(); #1;
      chk("cfl_lv", load_valid, 1);
      chk("cfl_ld", load_data, 32'hCAFEF00D);
      chk("cfl_dcst", dc_store, 0);
      chk("cfl_dcaddr", dc_addr, 32'h300);
      step(); idle_req(); dc_hit = 0;

      // load while draining waits for the pop, then goes to the cache
      drive(1, 1, 32'h500, 32'h55); step(); idle_req(); step();
      drive(0, 1, 32'h400, 0); dc_data_out = 32'h12345678; #1;
      chk("lock_stall", stall, 1);
      chk("lock_addr", dc_addr, 32'h500);
      step(); dc_hit = 1; #1;
      chk("lock_pop_stall", stall, 1);
      step(); dc_hit = 0; #1;
      chk("lock_issue_en", dc_enable, 1);
      chk("lock_issue_st", dc_store, 0);
      chk("lock_issue_addr", dc_addr, 32'h400);
      step(); dc_hit = 1; #1;
      chk("lock_lv", load_valid, 1);
      chk("lock_ld", load_data, 32'h12345678);
      step(); idle_req(); dc_hit = 0;

      // reset mid-drain
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h600 + 32'(4 * i), 32'hA0 + 32'(i)); step();
      end
      idle_req(); step();
      rst = 1; #1;
      chk("rstm_en", dc_enable, 0);
      chk("rstm_empty", empty, 1);
      step(); rst = 0; #1;
      chk("rstm_stall", stall, 0);
      chk("rstm_empty2", empty, 1);
      step();

      // fence holds a store until the buffer empties
      drive(1, 1, 32'h700, 32'h77); step();
      fence = 1; drive(1, 1, 32'h704, 32'h78); #1;
      chk("fence_stall", stall, 1);
      step(); dc_hit = 1; #1;
      chk("fence_stall2", stall, 1);
      step(); dc_hit = 0; #1;
      chk("fence_release", stall, 0);
      step(); fence = 0; idle_req(); dc_hit = 1; step(); dc_hit = 0; #1;
      chk("fence_empty", empty, 1);

      // youngest match and byte/byte forwarding
      drive(1, 1, 32'h900, 32'h1); step();
      drive(1, 1, 32'h900, 32'h2); step();
      drive(1, 0, 32'h803, 32'h5A); step();
      drive(0, 1, 32'h900, 0); #1;
`ifdef STORE_BUFFER_FORWARD_EN
      chk("young_ld", load_data, 32'h2);
`else
      chk("young_stall", stall, 1);
`endif
      step(); drive(0, 0, 32'h803, 0); #1;
`ifdef STORE_BUFFER_FORWARD_EN
      chk("bb_ld", load_data, 32'h5A);
`else
      chk("bb_stall", stall, 1);
`endif
      step(); drive(0, 0, 32'h802, 0); #1;
      chk("bb_conflict", stall, 1);
      step(); idle_req(); dc_hit = 1;
      step(); step(); step(); dc_hit = 0; #1;
      chk("final_empty", empty, 1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
